pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_perf.sv | 22 ++
 rtl/pipe_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned MDU_LAT_DEFAULT = 4;
  localparam int unsigned REG_W           = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef logic [0:0] state_t;

  localparam state_t ST_RUN      = 1'b0;
  localparam state_t ST_MDU_WAIT = 1'b1;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Stall and flush cycle counters; only instantiated when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);

  // Free-running counters, wrap naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_cycles <= 32'd0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (flush) flush_cycles <= flush_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, MDU wait and memory freeze.
// Optional stall/flush performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEFAULT,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mem_busy,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mdu_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_cycles
`endif
);

  if ((MDU_LAT < 1) || (MDU_LAT > 15) || ((MDU_LAT - 1) >= (1 << CNT_W))) begin : g_bad_lat
    $error("pipe_ctrl: MDU_LAT out of range for CNT_W");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load_use;
  logic             freeze;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Hazard decode, next-state and output selection; reset forces all outputs low.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mdu_busy   = 1'b0;

    load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (ex_rt == id_rt));
    freeze   = mem_busy || (state == ST_MDU_WAIT);

    if (!reset) begin
      mdu_busy = (state == ST_MDU_WAIT);
      if (freeze) begin
        // The MDU countdown only advances while memory is ready.
        if ((state == ST_MDU_WAIT) && !mem_busy) begin
          if (cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end else if (load_use) begin
        idex_load  = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        idex_load  = 1'b1;
        ifid_flush = branch_taken;
        if (mdu_start) begin
          state_nxt = ST_MDU_WAIT;
          cnt_nxt   = CNT_W'(MDU_LAT - 1);
        end
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clock        (clock),
    .reset        (reset),
    .stall        (!pc_load),
    .flush        (ifid_flush || idex_flush),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, multi-cycle sequences, randomized run vs. model.
module tb_pipe_ctrl;

  localparam int unsigned LAT = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, branch_taken, mdu_start, mem_busy;
  logic       pc_load, ifid_load, idex_load, ifid_flush, idex_flush, mdu_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  always #5 clock = ~clock;

  pipe_ctrl #(.MDU_LAT(LAT), .CNT_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_rt        (ex_rt),
    .ex_mem_read  (ex_mem_read),
    .branch_taken (branch_taken),
    .mdu_start    (mdu_start),
    .mem_busy     (mem_busy),
    .pc_load      (pc_load),
    .ifid_load    (ifid_load),
    .idex_load    (idex_load),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .mdu_busy     (mdu_busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: remaining MDU frozen cycles and performance totals.
  int          m_wait  = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs, rt, ert;
    logic       rd, br, ms, mb;
    logic [5:0] exp;  // {pc_load, ifid_load, idex_load, ifid_flush, idex_flush, mdu_busy}
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {pc_load, ifid_load, idex_load, ifid_flush, idex_flush, mdu_busy};
  endfunction

  function automatic bit model_load_use();
    return ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  function automatic logic [5:0] model_out();
    if (reset) return 6'b000000;
    if (mem_busy || (m_wait > 0)) return {5'b00000, (m_wait > 0)};
    if (model_load_use()) return 6'b001010;
    return {3'b111, branch_taken, 2'b00};
  endfunction

  task automatic model_step();
    logic [5:0] o;
    o = model_out();
    if (reset) begin
      m_wait  = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!o[5]) m_stall++;
      if (o[2] || o[1]) m_flush++;
      if (m_wait > 0) begin
        if (!mem_busy) m_wait--;
      end else if (!mem_busy && !model_load_use() && mdu_start) begin
        m_wait = LAT;
      end
    end
  endtask

  task automatic set_in(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ert, input logic rd, input logic br,
                        input logic ms, input logic mb);
    reset = rst; id_rs = rs; id_rt = rt; ex_rt = ert;
    ex_mem_read = rd; branch_taken = br; mdu_start = ms; mem_busy = mb;
  endtask

  // One cycle: sample between edges, compare, advance model across the rising edge.
  task automatic step(input string name, input bit use_exp, input logic [5:0] exp);
    #2;
    cmp(name, 64'(dut_out()), use_exp ? 64'(exp) : 64'(model_out()));
`ifdef PIPE_CTRL_PERF_EN
    cmp({name, "_stall_cnt"}, 64'(stall_cycles), 64'(m_stall));
    cmp({name, "_flush_cnt"}, 64'(flush_cycles), 64'(m_flush));
`endif
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Count frozen cycles after an MDU issue, with mem_busy raised for wait cycles [mb_from, mb_to).
  task automatic count_frozen(input string name, input int mb_from, input int mb_to,
                              input int exp_n);
    int n;
    bit done;
    n = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      mem_busy = (k >= mb_from) && (k < mb_to);
      #1;
      if (pc_load === 1'b1) done = 1;
      else n++;
      #1;
      cmp({name, "_cyc"}, 64'(dut_out()), 64'(model_out()));
      model_step();
      @(posedge clock);
      @(negedge clock);
    end
    mem_busy = 1'b0;
    cmp({name, "_done"}, 64'(done), 64'(1));
    cmp({name, "_frozen"}, 64'(n), 64'(exp_n));
  endtask

  initial begin
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);

    //          name            rst rs     rt     ert    rd br ms mb  exp
    tbl.push_back('{"reset",     1, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 6'b000000});
    tbl.push_back('{"idle",      0, 5'd1, 5'd2, 5'd3,  0, 0, 0, 0, 6'b111000});
    tbl.push_back('{"lu_rs",     0, 5'd5, 5'd2, 5'd5,  1, 0, 0, 0, 6'b001010});
    tbl.push_back('{"lu_after",  0, 5'd5, 5'd2, 5'd5,  0, 0, 0, 0, 6'b111000});
    tbl.push_back('{"lu_zero",   0, 5'd0, 5'd1, 5'd0,  1, 0, 0, 0, 6'b111000});
    tbl.push_back('{"lu_rt",     0, 5'd1, 5'd7, 5'd7,  1, 0, 0, 0, 6'b001010});
    tbl.push_back('{"branch",    0, 5'd1, 5'd2, 5'd3,  0, 1, 0, 0, 6'b111100});
    tbl.push_back('{"br_membusy",0, 5'd1, 5'd2, 5'd3,  0, 1, 0, 1, 6'b000000});
    tbl.push_back('{"br_ms_lu",  0, 5'd3, 5'd2, 5'd3,  1, 1, 1, 0, 6'b001010});
    tbl.push_back('{"after_lu",  0, 5'd1, 5'd2, 5'd3,  0, 0, 0, 0, 6'b111000});
    tbl.push_back('{"mdu_br",    0, 5'd1, 5'd2, 5'd3,  0, 1, 1, 0, 6'b111100});
    tbl.push_back('{"mdu_w1",    0, 5'd1, 5'd2, 5'd3,  0, 1, 0, 0, 6'b000001});
    tbl.push_back('{"mdu_w2",    0, 5'd1, 5'd2, 5'd3,  0, 0, 1, 0, 6'b000001});
    tbl.push_back('{"mdu_w3",    0, 5'd1, 5'd2, 5'd3,  0, 0, 0, 0, 6'b000001});
    tbl.push_back('{"mdu_w4",    0, 5'd1, 5'd2, 5'd3,  1, 0, 0, 0, 6'b000001});
    tbl.push_back('{"mdu_done",  0, 5'd1, 5'd2, 5'd3,  0, 0, 0, 0, 6'b111000});
    tbl.push_back('{"ms_membusy",0, 5'd1, 5'd2, 5'd3,  0, 0, 1, 1, 6'b000000});
    tbl.push_back('{"ms_ignored",0, 5'd1, 5'd2, 5'd3,  0, 0, 0, 0, 6'b111000});

    foreach (tbl[i]) begin
      set_in(tbl[i].rst, tbl[i].rs, tbl[i].rt, tbl[i].ert,
             tbl[i].rd, tbl[i].br, tbl[i].ms, tbl[i].mb);
      step(tbl[i].name, 1'b1, tbl[i].exp);
    end

    // MDU pulse with no memory stalls: exactly LAT frozen cycles.
    set_in(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step("seq_lat_issue", 1'b1, 6'b111000);
    mdu_start = 1'b0;
    count_frozen("seq_lat", 0, 0, LAT);

    // Memory stall for three cycles mid-wait extends the freeze to LAT+3.
    mdu_start = 1'b1;
    step("seq_mb_issue", 1'b1, 6'b111000);
    mdu_start = 1'b0;
    count_frozen("seq_mb", 1, 4, LAT + 3);

    // Reset in the middle of an MDU wait aborts it.
    mdu_start = 1'b1;
    step("seq_rst_issue", 1'b1, 6'b111000);
    mdu_start = 1'b0;
    step("seq_rst_wait", 1'b1, 6'b000001);
    reset = 1'b1;
    step("seq_rst_hold", 1'b1, 6'b000000);
    reset = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
    #1;
    cmp("seq_rst_stall_zero", 64'(stall_cycles), 64'(0));
    cmp("seq_rst_flush_zero", 64'(flush_cycles), 64'(0));
    #1;
    step("seq_rst_run", 1'b1, 6'b111000);
`else
    step("seq_rst_run", 1'b1, 6'b111000);
`endif

    // Randomized traffic against the model; small register range provokes hazards.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 99) == 0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
      step("rand", 1'b0, 6'b000000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
